// File: rtl/spike_pkg.sv
`default_nettype none
//============================================================================
// Package     : spike_pkg
// Description : Shared spike event type and address field positions.
// Revision    : 1.0 - initial release
//============================================================================
package spike_pkg;

    localparam int SPIKE_TS_W  = 16;
    localparam int ROW_ADDR_HI = 15;
    localparam int ROW_ADDR_LO = 8;

    typedef struct packed {
        logic [15:0]           address;
        logic                  on_off;
        logic [SPIKE_TS_W-1:0] ts;
    } spike_event_t;

endpackage
`default_nettype wire

// File: rtl/spike_if.sv
`default_nettype none
//============================================================================
// Interface   : spike_if
// Description : Spike stream link (row select in [15:8], synapse in [7:0]).
// Revision    : 1.0 - initial release
//============================================================================
interface spike_if;
    logic        valid;
    logic [15:0] address;
    logic        on_off;

    modport master (output valid, output address, output on_off);
    modport slave  (input  valid, input  address, input  on_off);
endinterface
`default_nettype wire

// File: rtl/spike_event_fifo.sv
`default_nettype none
//============================================================================
// Module      : spike_event_fifo
// Description : Synchronous FIFO of spike_event_t with occupancy count.
// Revision    : 1.0 - initial release
//============================================================================
module spike_event_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  spike_event_t             push_data,
    input  logic                     pop,
    output spike_event_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    spike_event_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_event_scheduler.sv
`default_nettype none
//============================================================================
// Module      : spike_event_scheduler
// Description : Buffers timestamped spike events and releases each onto
//               spike_if once system time reaches its timestamp.
//               Define SPIKE_DROP_LATE_EN to drop events older than LATE_MAX.
// Revision    : 1.0 - initial release
//============================================================================
module spike_event_scheduler
    import spike_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_W     = SPIKE_TS_W,
    parameter int LATE_MAX = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [15:0]              ev_address,
    input  logic                     ev_on_off,
    input  logic [TS_W-1:0]          ev_time,
    input  logic                     time_en,
    output logic [TS_W-1:0]          now,
    spike_if.master                  spike_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              late_drops
);

    spike_event_t   w_push_data;
    spike_event_t   w_head;
    logic           w_full;
    logic           w_empty;
    logic [TS_W-1:0] w_diff;
    logic           w_eligible;
    logic           w_late;

    logic [TS_W-1:0] r_now;
    logic           r_valid;
    logic [15:0]    r_address;
    logic           r_on_off;

    assign w_push_data = '{address: ev_address, on_off: ev_on_off, ts: SPIKE_TS_W'(ev_time)};

    spike_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_valid),
        .push_data (w_push_data),
        .pop       (w_eligible),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    // Signed age of the head event; non-negative means its time has come.
    assign w_diff     = r_now - TS_W'(w_head.ts);
    assign w_eligible = !w_empty && !w_diff[TS_W-1];
    assign ev_ready   = !w_full;
    assign now        = r_now;

`ifdef SPIKE_DROP_LATE_EN
    logic [15:0] r_late_drops;

    assign w_late     = (w_diff > TS_W'(LATE_MAX));
    assign late_drops = r_late_drops;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_late_drops <= '0;
        end else if (w_eligible && w_late && (r_late_drops != 16'hFFFF)) begin
            r_late_drops <= r_late_drops + 1'b1;
        end
    end
`else
    logic w_unused_late_cmp;

    assign w_unused_late_cmp = (w_diff > TS_W'(LATE_MAX));
    assign w_late            = 1'b0;
    assign late_drops        = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_now     <= '0;
            r_valid   <= 1'b0;
            r_address <= '0;
            r_on_off  <= 1'b0;
        end else begin
            if (time_en) begin
                r_now <= r_now + 1'b1;
            end
            if (w_eligible && !w_late) begin
                r_valid   <= 1'b1;
                r_address <= w_head.address;
                r_on_off  <= w_head.on_off;
            end else begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign spike_out.valid   = r_valid;
    assign spike_out.address = r_address;
    assign spike_out.on_off  = r_on_off;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_scheduler.sv
`default_nettype none
//============================================================================
// Module      : tb_spike_event_scheduler
// Description : Self-checking bench for spike_event_scheduler.
// Revision    : 1.0 - initial release
//============================================================================
module tb_spike_event_scheduler;

    localparam int DEPTH    = 16;
    localparam int TS_W     = 16;
    localparam int LATE_MAX = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_address;
    logic        ev_on_off;
    logic [15:0] ev_time;
    logic        time_en;
    logic [15:0] now;
    logic [4:0]  fifo_count;
    logic [15:0] late_drops;

    spike_if u_spk ();

    spike_event_scheduler #(
        .DEPTH    (DEPTH),
        .TS_W     (TS_W),
        .LATE_MAX (LATE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_address (ev_address),
        .ev_on_off  (ev_on_off),
        .ev_time    (ev_time),
        .time_en    (time_en),
        .now        (now),
        .spike_out  (u_spk),
        .fifo_count (fifo_count),
        .late_drops (late_drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        on;
        logic [15:0] ts;
    } ev_t;

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic        o;
        logic [15:0] t;
        logic        te;
        logic        exp_valid;
        logic [15:0] exp_addr;
        logic        exp_on;
        int          exp_cnt;
        logic [15:0] exp_now;
    } vec_t;

    // Reference model state: a queue of pending events plus output image.
    ev_t         m_q[$];
    logic [15:0] m_now, m_addr, m_drops;
    logic        m_valid, m_on, m_accepted;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [15:0] a, input logic o,
                              input logic [15:0] t, input logic te);
        logic [15:0] diff;
        logic        ready_pre, late;
        ev_t         e;
        ready_pre = (m_q.size() < DEPTH);
        m_valid   = 1'b0;
        if (m_q.size() > 0) begin
            diff = m_now - m_q[0].ts;
            if ($signed(diff) >= 0) begin
                e    = m_q.pop_front();
                late = 1'b0;
`ifdef SPIKE_DROP_LATE_EN
                late = (diff > 16'(LATE_MAX));
`endif
                if (late) begin
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                end else begin
                    m_valid = 1'b1;
                    m_addr  = e.addr;
                    m_on    = e.on;
                end
            end
        end
        m_accepted = v && ready_pre;
        if (m_accepted) m_q.push_back('{a, o, t});
        if (te) m_now = m_now + 16'd1;
    endtask

    task automatic compare_all();
        chk("valid",      u_spk.valid,   m_valid);
        chk("address",    u_spk.address, m_addr);
        chk("on_off",     u_spk.on_off,  m_on);
        chk("fifo_count", fifo_count,    m_q.size());
        chk("now",        now,           m_now);
        chk("ev_ready",   ev_ready,      (m_q.size() < DEPTH));
        chk("late_drops", late_drops,    m_drops);
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic o,
                        input logic [15:0] t, input logic te);
        ev_valid   = v;
        ev_address = a;
        ev_on_off  = o;
        ev_time    = t;
        time_en    = te;
        @(posedge clk);
        model_edge(v, a, o, t, te);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ev_valid = 1'b0;
        time_en  = 1'b0;
        @(posedge clk);
        m_q.delete();
        m_now   = '0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_on    = 1'b0;
        m_drops = '0;
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    vec_t        tbl[5];
    logic [15:0] got_addr[$];
    int          got_cyc[$];
    logic [15:0] first_now;
    int          seen;
    logic        held_accepted;

    initial begin
        reset = 1'b1; ev_valid = 1'b0; ev_address = '0; ev_on_off = 1'b0;
        ev_time = '0; time_en = 1'b0;

        // Directed vectors from reset: push ts=0 at now=0, single-cycle spike.
        tbl[0] = '{1'b1, 16'h0305, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 16'd0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0305, 1'b1, 0, 16'd0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0305, 1'b1, 0, 16'd0};
        tbl[3] = '{1'b1, 16'hABCD, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0305, 1'b1, 1, 16'd1};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0, 0, 16'd1};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].o, tbl[i].t, tbl[i].te);
            chk("tbl_valid", u_spk.valid,   tbl[i].exp_valid);
            chk("tbl_addr",  u_spk.address, tbl[i].exp_addr);
            chk("tbl_on",    u_spk.on_off,  tbl[i].exp_on);
            chk("tbl_count", fifo_count,    tbl[i].exp_cnt);
            chk("tbl_now",   now,           tbl[i].exp_now);
        end

        // ts=10 with time advancing every cycle: popped while now==10.
        do_reset();
        step(1'b1, 16'h0010, 1'b0, 16'd10, 1'b0);
        seen = 0; first_now = '0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
            if (u_spk.valid) begin
                seen++;
                first_now = now;
            end
        end
        chk("ts10_spikes", seen, 1);
        chk("ts10_now_after_emit", first_now, 16'd11);

        // Fill to DEPTH, hold a 17th event, then release back-to-back.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 1'(i), 16'd100, 1'b0);
        chk("fill_ready", ev_ready, 1'b0);
        chk("fill_count", fifo_count, DEPTH);
        held_accepted = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, 16'h0999, 1'b1, 16'd100, 1'b1);
            if (m_accepted) held_accepted = 1'b1;
        end
        chk("held_count", fifo_count, DEPTH);
        chk("held_not_taken", held_accepted, 1'b0);
        got_addr.delete(); got_cyc.delete();
        for (int c = 0; c < 30; c++) begin
            step(!held_accepted, 16'h0999, 1'b1, 16'd100, 1'b0);
            if (m_accepted) held_accepted = 1'b1;
            if (u_spk.valid) begin
                got_addr.push_back(u_spk.address);
                got_cyc.push_back(c);
            end
        end
        chk("burst_len", got_addr.size(), DEPTH + 1);
        if (got_addr.size() == DEPTH + 1) begin
            for (int i = 0; i < DEPTH; i++) chk("burst_order", got_addr[i], 16'(i));
            chk("burst_last", got_addr[DEPTH], 16'h0999);
            chk("burst_span", got_cyc[DEPTH] - got_cyc[0], DEPTH);
        end

        // Late-event handling at now=200.
        do_reset();
        for (int c = 0; c < 200; c++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0777, 1'b1, 16'd100, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
`ifdef SPIKE_DROP_LATE_EN
        chk("late_no_spike", u_spk.valid, 1'b0);
        chk("late_drop_cnt", late_drops, 16'd1);
`else
        chk("late_emitted", u_spk.valid, 1'b1);
        chk("late_addr", u_spk.address, 16'h0777);
`endif
        step(1'b1, 16'h0888, 1'b0, 16'd180, 1'b0);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        chk("recent_emitted", u_spk.valid, 1'b1);
        chk("recent_addr", u_spk.address, 16'h0888);

        // Reset with pending events discards them.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), 1'b1, 16'd3 + 16'(i), 1'b0);
        chk("pending_count", fifo_count, 5);
        do_reset();
        chk("flushed_count", fifo_count, 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
            if (u_spk.valid) seen++;
        end
        chk("flushed_no_spike", seen, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int unsigned r;
            logic [15:0] ts;
            r = $urandom % 10;
            if (r < 7)      ts = m_now + 16'($urandom_range(0, 12));
            else if (r < 9) ts = m_now - 16'($urandom_range(0, 20));
            else            ts = m_now - 16'($urandom_range(60, 200));
            step(1'($urandom % 2), 16'($urandom), 1'($urandom), ts, ($urandom % 4) != 0);
        end

        // Timestamp wrap: now=FFF0, ts=0004 released only after wrap.
        do_reset();
        for (int i = 0; i < 16'hFFF0; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        chk("wrap_start_now", now, 16'hFFF0);
        step(1'b1, 16'h0404, 1'b0, 16'h0004, 1'b0);
        seen = 0; first_now = '0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
            if (u_spk.valid) begin
                if (seen == 0) first_now = now;
                seen++;
            end
        end
        chk("wrap_spikes", seen, 1);
        chk("wrap_now_after_emit", first_now, 16'h0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
